if_id_skid_buffer: RTL

//  IF/ID pipeline boundary buffer: captures fetched instruction + PC+4 from IF, presents them to ID.
//  ID extracts register fields and the 16-bit immediate (o_imm16) for sign extension.
//  Two-entry skid buffer (main + skid) with valid/ready handshake on both sides.
//  ID can stall (load-use hazard) without dropping the instruction IF delivered that cycle.

---
 rtl/if_id_skid_buffer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer
//   IF/ID pipeline boundary buffer with two entries (main + skid) and a
//   valid/ready handshake on both sides. ID can stall without IF losing the
//   instruction it handed over in the same cycle, and a synchronous flush
//   squashes every held entry on a taken branch/jump.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous reset, active low (overrides flush and transfers)
//   i_flush      squash all held entries; a same-cycle accept is discarded
//   i_valid      IF presents i_instr / i_pc_plus4
//   i_instr      fetched instruction
//   i_pc_plus4   PC+4 of the fetched instruction
//   o_ready      buffer can accept next cycle (registered)
//   o_valid      head entry valid for ID
//   o_instr      head instruction, 0 (NOP) when !o_valid
//   o_pc_plus4   head PC+4, 0 when !o_valid
//   o_imm16      o_instr[NB_IMM-1:0]
//   i_ready      ID consumes the head this cycle; low = stall
//   o_occupancy  number of entries held (0..2)
module if_id_skid_buffer #(
   parameter int unsigned NB_INSTR = 32,
   parameter int unsigned NB_PC    = 32,
   parameter int unsigned NB_IMM   = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_flush,
   input  logic                i_valid,
   input  logic [NB_INSTR-1:0] i_instr,
   input  logic [NB_PC-1:0]    i_pc_plus4,
   output logic                o_ready,
   output logic                o_valid,
   output logic [NB_INSTR-1:0] o_instr,
   output logic [NB_PC-1:0]    o_pc_plus4,
   output logic [NB_IMM-1:0]   o_imm16,
   input  logic                i_ready,
   output logic [1:0]          o_occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t              state, state_next;
   logic                ready_q;
   logic [NB_INSTR-1:0] main_instr, skid_instr;
   logic [NB_PC-1:0]    main_pc, skid_pc;

   logic accept, consume;
   logic load_main_in, load_skid_in, load_main_skid;

   assign accept  = i_valid & ready_q;
   assign consume = (state != EMPTY) & i_ready;

   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_skid_in   = 1'b0;
      load_main_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_next   = ONE;
               load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (accept && consume) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               state_next   = TWO;
               load_skid_in = 1'b1;
            end else if (consume) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            // ready_q is low here, so nothing can be accepted
            if (consume) begin
               state_next     = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
      // Flush wins over any transfer; the consume has already happened on ID's side
      if (i_flush) begin
         state_next     = EMPTY;
         load_main_in   = 1'b0;
         load_skid_in   = 1'b0;
         load_main_skid = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_next;
         ready_q <= (state_next != TWO);
      end
   end

   // Data only loads on an accept (which implies i_valid), so X on the
   // inputs while !i_valid never reaches the entries.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         main_instr <= '0;
         main_pc    <= '0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else begin
         if (load_main_in) begin
            main_instr <= i_instr;
            main_pc    <= i_pc_plus4;
         end else if (load_main_skid) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
         end
         if (load_skid_in) begin
            skid_instr <= i_instr;
            skid_pc    <= i_pc_plus4;
         end
      end
   end

   always_comb begin
      o_occupancy = 2'd0;
      case (state)
         ONE:     o_occupancy = 2'd1;
         TWO:     o_occupancy = 2'd2;
         default: o_occupancy = 2'd0;
      endcase
   end

   assign o_ready    = ready_q;
   assign o_valid    = (state != EMPTY);
   assign o_instr    = o_valid ? main_instr : '0;
   assign o_pc_plus4 = o_valid ? main_pc : '0;
   assign o_imm16    = o_instr[NB_IMM-1:0];

endmodule
